// File: rtl/eth_tx_frame_arbiter_pkg.sv
// Shared types for the Ethernet TX frame arbiter.
// ABORT/DRAIN states exist only when ETH_TX_ARB_WATCHDOG_EN is defined.
package eth_tx_arb_pkg;

`ifdef ETH_TX_ARB_WATCHDOG_EN
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1, ABORT = 2'd2, DRAIN = 2'd3} arb_state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, PASS = 2'd1} arb_state_t;
`endif

  // Next index in the rotation, wrapping at n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1) % n;
  endfunction

endpackage

// File: rtl/eth_tx_frame_arbiter_rr_select.sv
// Combinational round-robin pick: first requester at or after last+1.
module rr_priority_select
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int IDX_W     = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] i_req,
  input  logic [IDX_W-1:0]     i_last,
  output logic [IDX_W-1:0]     o_idx,
  output logic                 o_valid
);

  logic [NUM_PORTS-1:0][IDX_W-1:0] w_cand;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_cand
    assign w_cand[k] = IDX_W'(rr_next(int'(i_last) + k, NUM_PORTS));
  end

  // Scan from lowest priority up so the highest-priority hit is written last.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) begin
        o_idx   = w_cand[k];
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eth_tx_frame_arbiter.sv
// Frame-granular round-robin arbiter in front of the MAC TX AXI-Stream sink.
// Define ETH_TX_ARB_WATCHDOG_EN to abort and drain frames stalled mid-transfer.
module eth_tx_frame_arbiter
  import eth_tx_arb_pkg::*;
#(
  parameter int NUM_PORTS      = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]            s_tvalid,
  input  logic [NUM_PORTS-1:0]            s_tlast,
  input  logic [NUM_PORTS-1:0]            s_tuser,
  output logic [NUM_PORTS-1:0]            s_tready,
  output logic [DATA_WIDTH-1:0]           m_tdata,
  output logic                            m_tvalid,
  output logic                            m_tlast,
  output logic                            m_tuser,
  input  logic                            m_tready,
  output logic                            grant_active,
  output logic [$clog2(NUM_PORTS)-1:0]    grant_idx,
  output logic                            frame_done,
  output logic                            frame_aborted
);

  localparam int IW = $clog2(NUM_PORTS);

  if (NUM_PORTS < 2 || NUM_PORTS > 8 || TIMEOUT_CYCLES < 2) begin : g_param_err
    $error("eth_tx_frame_arbiter: parameter out of range");
  end

  arb_state_t            r_state, w_state_nxt;
  logic [IW-1:0]         r_grant_idx, r_last_grant, w_sel_idx;
  logic                  r_grant_active, r_frame_done;
  logic                  w_sel_vld, w_grant, w_done, w_end;
  logic                  w_g_valid, w_g_last, w_g_user;
  logic [DATA_WIDTH-1:0] w_g_data;

  assign w_g_valid = s_tvalid[r_grant_idx];
  assign w_g_last  = s_tlast[r_grant_idx];
  assign w_g_user  = s_tuser[r_grant_idx];
  assign w_g_data  = s_tdata[r_grant_idx*DATA_WIDTH +: DATA_WIDTH];

  rr_priority_select #(.NUM_PORTS(NUM_PORTS), .IDX_W(IW)) u_sel (
    .i_req   (s_tvalid),
    .i_last  (r_last_grant),
    .o_idx   (w_sel_idx),
    .o_valid (w_sel_vld)
  );

`ifdef ETH_TX_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] r_wd_cnt;
  logic            w_wd_expire, w_abort, r_frame_aborted;

  // Only cycles with no source data count; backpressure from the MAC does not.
  assign w_wd_expire = !w_g_valid && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wd_cnt        <= '0;
      r_frame_aborted <= 1'b0;
    end else begin
      r_frame_aborted <= w_abort;
      if (r_state != PASS || (w_g_valid && m_tready)) r_wd_cnt <= '0;
      else if (!w_g_valid)                            r_wd_cnt <= r_wd_cnt + 1'b1;
    end
  end

  assign frame_aborted = r_frame_aborted;
`else
  assign frame_aborted = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done      = 1'b0;
    w_end       = 1'b0;
    s_tready    = '0;
    m_tvalid    = 1'b0;
    m_tlast     = 1'b0;
    m_tuser     = 1'b0;
    m_tdata     = '0;
`ifdef ETH_TX_ARB_WATCHDOG_EN
    w_abort     = 1'b0;
`endif
    case (r_state)
      IDLE: begin
        if (enable && w_sel_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = PASS;
        end
      end
      PASS: begin
        m_tvalid               = w_g_valid;
        m_tlast                = w_g_last;
        m_tuser                = w_g_user;
        m_tdata                = w_g_data;
        s_tready[r_grant_idx]  = m_tready;
        if (w_g_valid && m_tready && w_g_last) begin
          w_done      = 1'b1;
          w_end       = 1'b1;
          w_state_nxt = IDLE;
        end
`ifdef ETH_TX_ARB_WATCHDOG_EN
        else if (w_wd_expire) w_state_nxt = ABORT;
`endif
      end
`ifdef ETH_TX_ARB_WATCHDOG_EN
      // Poisoned tlast beat makes the MAC FIFO discard the partial frame.
      ABORT: begin
        m_tvalid = 1'b1;
        m_tlast  = 1'b1;
        m_tuser  = 1'b1;
        if (m_tready) begin
          w_abort     = 1'b1;
          w_state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        s_tready[r_grant_idx] = 1'b1;
        if (w_g_valid && w_g_last) begin
          w_end       = 1'b1;
          w_state_nxt = IDLE;
        end
      end
`endif
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_grant_idx    <= '0;
      r_last_grant   <= IW'(NUM_PORTS - 1);
      r_grant_active <= 1'b0;
      r_frame_done   <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_frame_done <= w_done;
      if (w_grant) begin
        r_grant_idx    <= w_sel_idx;
        r_grant_active <= 1'b1;
      end else if (w_end) begin
        r_last_grant   <= r_grant_idx;
        r_grant_active <= 1'b0;
      end
    end
  end

  assign grant_active = r_grant_active;
  assign grant_idx    = r_grant_idx;
  assign frame_done   = r_frame_done;

endmodule

// File: tb/tb_eth_tx_frame_arbiter.sv
// Bench for eth_tx_frame_arbiter: per-port source queues, output scoreboard,
// cycle table for the basic flows and hand-written corner sequences.
`timescale 1ns/1ps
module tb_eth_tx_frame_arbiter;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  typedef struct packed { logic [7:0] d; logic l; logic u; } beat_t;
  typedef struct packed { logic [7:0] d; logic l; logic u; logic [1:0] p; } exp_t;
  typedef struct {
    int         ld;
    bit         en;
    bit         rdy;
    bit         x_act;
    logic [1:0] x_idx;
    bit         x_mv;
    bit         x_done;
    logic [3:0] x_srdy;
  } vec_t;

  logic              clk, reset_n, enable, m_tready;
  logic [NP*DW-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid, s_tlast, s_tuser, s_tready;
  logic [DW-1:0]     m_tdata;
  logic              m_tvalid, m_tlast, m_tuser;
  logic              grant_active, frame_done, frame_aborted;
  logic [1:0]        grant_idx;

  eth_tx_frame_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tuser(s_tuser),
    .s_tready(s_tready),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser(m_tuser),
    .m_tready(m_tready),
    .grant_active(grant_active), .grant_idx(grant_idx),
    .frame_done(frame_done), .frame_aborted(frame_aborted)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  beat_t src_mem [NP][32];
  int    src_rd  [NP];
  int    src_wr  [NP];
  bit    fire    [NP];
  exp_t  exp_q[$];
  int    errors = 0, checks = 0, done_cnt = 0, abort_cnt = 0;
  vec_t  tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_beat(input int p, input logic [7:0] d, input logic l, input logic u,
                           input bit push);
    src_mem[p][src_wr[p]] = '{d, l, u};
    src_wr[p]++;
    if (push) exp_q.push_back('{d, l, u, 2'(p)});
  endtask

  task automatic load_frame(input int p, input logic [7:0] base, input logic [7:0] step,
                            input int n, input bit ulast, input bit push);
    for (int k = 0; k < n; k++)
      load_beat(p, 8'(base + k * step), k == n - 1, (k == n - 1) && ulast, push);
  endtask

  task automatic drive_src();
    for (int i = 0; i < NP; i++) begin
      if (src_rd[i] < src_wr[i]) begin
        s_tvalid[i]        = 1'b1;
        s_tdata[i*DW +: DW] = src_mem[i][src_rd[i]].d;
        s_tlast[i]         = src_mem[i][src_rd[i]].l;
        s_tuser[i]         = src_mem[i][src_rd[i]].u;
      end else begin
        s_tvalid[i]        = 1'b0;
        s_tdata[i*DW +: DW] = '0;
        s_tlast[i]         = 1'b0;
        s_tuser[i]         = 1'b0;
      end
    end
  endtask

  // Drive, then sample at the falling edge and run the output scoreboard.
  task automatic half_a();
    exp_t e;
    drive_src();
    @(negedge clk);
    for (int i = 0; i < NP; i++) fire[i] = s_tvalid[i] && s_tready[i];
    done_cnt  += int'(frame_done);
    abort_cnt += int'(frame_aborted);
    chk("sready_grant_only", s_tready & ~(4'b0001 << grant_idx), 0);
    if (m_tvalid && m_tready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got data 0x%0h last %0b user %0b port %0d expected none at %0t",
                 m_tdata, m_tlast, m_tuser, grant_idx, $time);
      end else begin
        e = exp_q.pop_front();
        chk("beat", {m_tdata, m_tlast, m_tuser, grant_idx}, e);
      end
    end
  endtask

  task automatic half_b();
    @(posedge clk);
    #1;
    for (int i = 0; i < NP; i++) if (fire[i]) src_rd[i]++;
  endtask

  task automatic tick();
    half_a();
    half_b();
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_grant_active"}, grant_active, 0);
    chk({tag, "_grant_idx"}, grant_idx, 0);
    chk({tag, "_s_tready"}, s_tready, 0);
    chk({tag, "_m_tvalid"}, m_tvalid, 0);
    chk({tag, "_frame_done"}, frame_done, 0);
    chk({tag, "_frame_aborted"}, frame_aborted, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int n, d0;
    bit seen;
    reset_n  = 1'b0;
    enable   = 1'b0;
    m_tready = 1'b0;
    s_tdata  = '0;
    s_tvalid = '0;
    s_tlast  = '0;
    s_tuser  = '0;

    // ld: 1 = port2 {AA,BB,CC}; 2 = port1 {11,12,13(tuser)}; 3 = port0 {01,02}
    //            ld en rdy act idx   mv    done  srdy
    tbl[0]  = '{1, 1, 1, 0, 2'd0, 0, 0, 4'b0000};
    tbl[1]  = '{0, 1, 1, 1, 2'd2, 1, 0, 4'b0100};
    tbl[2]  = '{0, 1, 1, 1, 2'd2, 1, 0, 4'b0100};
    tbl[3]  = '{0, 1, 1, 1, 2'd2, 1, 0, 4'b0100};
    tbl[4]  = '{0, 1, 1, 0, 2'd2, 0, 1, 4'b0000};
    tbl[5]  = '{0, 1, 1, 0, 2'd2, 0, 0, 4'b0000};
    tbl[6]  = '{2, 1, 1, 0, 2'd2, 0, 0, 4'b0000};
    tbl[7]  = '{3, 1, 1, 1, 2'd1, 1, 0, 4'b0010};
    tbl[8]  = '{0, 1, 0, 1, 2'd1, 1, 0, 4'b0000};
    tbl[9]  = '{0, 1, 1, 1, 2'd1, 1, 0, 4'b0010};
    tbl[10] = '{0, 1, 0, 1, 2'd1, 1, 0, 4'b0000};
    tbl[11] = '{0, 1, 1, 1, 2'd1, 1, 0, 4'b0010};
    tbl[12] = '{0, 1, 1, 0, 2'd1, 0, 1, 4'b0000};
    tbl[13] = '{0, 1, 1, 1, 2'd0, 1, 0, 4'b0001};
    tbl[14] = '{0, 1, 1, 1, 2'd0, 1, 0, 4'b0001};
    tbl[15] = '{0, 1, 1, 0, 2'd0, 0, 1, 4'b0000};

    repeat (2) @(negedge clk);
    chk_rst("por");
    @(posedge clk);
    #1 reset_n = 1'b1;

    for (int r = 0; r < 16; r++) begin
      case (tbl[r].ld)
        1: load_frame(2, 8'hAA, 8'h11, 3, 1'b0, 1'b1);
        2: load_frame(1, 8'h11, 8'h01, 3, 1'b1, 1'b1);
        3: load_frame(0, 8'h01, 8'h01, 2, 1'b0, 1'b1);
        default: ;
      endcase
      enable   = tbl[r].en;
      m_tready = tbl[r].rdy;
      half_a();
      chk($sformatf("row%0d_grant_active", r), grant_active, tbl[r].x_act);
      chk($sformatf("row%0d_grant_idx", r), grant_idx, tbl[r].x_idx);
      chk($sformatf("row%0d_m_tvalid", r), m_tvalid, tbl[r].x_mv);
      chk($sformatf("row%0d_frame_done", r), frame_done, tbl[r].x_done);
      chk($sformatf("row%0d_s_tready", r), s_tready, tbl[r].x_srdy);
      half_b();
    end

    // enable low blocks new grants; dropping it mid-frame lets the frame finish
    enable   = 1'b0;
    m_tready = 1'b1;
    load_frame(1, 8'h41, 8'h01, 2, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      half_a();
      chk("en0_no_grant", {grant_active, m_tvalid}, 2'b00);
      half_b();
    end
    enable = 1'b1;
    tick();
    tick();
    enable = 1'b0;
    load_frame(2, 8'h51, 8'h01, 2, 1'b0, 1'b1);
    d0 = done_cnt;
    tick();
    for (int k = 0; k < 4; k++) begin
      half_a();
      chk("en_drop_no_regrant", {grant_active, m_tvalid}, 2'b00);
      half_b();
    end
    chk("en_drop_frame_done", done_cnt - d0, 1);
    chk("en_drop_pending", exp_q.size(), 2);
    enable = 1'b1;
    n = 0;
    while (exp_q.size() > 0 && n < 20) begin tick(); n++; end
    chk("en_resume_drained", exp_q.size(), 0);

    // asynchronous reset in the middle of a port 0 frame
    load_frame(0, 8'h61, 8'h01, 4, 1'b0, 1'b1);
    tick();
    tick();
    tick();
    half_a();
    chk("pre_rst_m_tvalid", m_tvalid, 1);
    #1 reset_n = 1'b0;
    #1;
    chk_rst("async");
    for (int i = 0; i < NP; i++) begin
      src_rd[i] = 0;
      src_wr[i] = 0;
      fire[i]   = 1'b0;
    end
    exp_q.delete();
    half_b();
    half_a();
    chk_rst("held");
    half_b();
    reset_n = 1'b1;

    // all ports busy: rotation 0,1,2,3,0 with one idle cycle between frames
    load_frame(0, 8'h01, 8'h01, 2, 1'b0, 1'b1);
    load_frame(1, 8'h11, 8'h01, 2, 1'b0, 1'b1);
    load_frame(2, 8'h21, 8'h01, 2, 1'b0, 1'b1);
    load_frame(3, 8'h31, 8'h01, 2, 1'b0, 1'b1);
    load_frame(0, 8'h05, 8'h01, 2, 1'b0, 1'b1);
    d0 = done_cnt;
    n  = 0;
    while (exp_q.size() > 0 && n < 100) begin tick(); n++; end
    chk("rr_cycles", n, 15);
    tick();
    chk("rr_frame_done", done_cnt - d0, 5);

`ifdef ETH_TX_ARB_WATCHDOG_EN
    load_beat(3, 8'h71, 1'b0, 1'b0, 1'b1);
    load_beat(3, 8'h72, 1'b0, 1'b0, 1'b1);
    exp_q.push_back('{8'h00, 1'b1, 1'b1, 2'd3});
    n = 0;
    while (exp_q.size() > 1 && n < 20) begin tick(); n++; end
    chk("wd_beats", n, 3);
    n    = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      half_a();
      if (m_tvalid) seen = 1'b1;
      else n++;
      half_b();
    end
    chk("wd_abort_seen", seen, 1);
    chk("wd_stall_cycles", n, TO);
    d0 = done_cnt;
    load_beat(3, 8'h73, 1'b0, 1'b0, 1'b0);
    load_beat(3, 8'h74, 1'b1, 1'b0, 1'b0);
    half_a();
    chk("wd_aborted_pulse", frame_aborted, 1);
    chk("wd_drain_s_tready", s_tready, 4'b1000);
    chk("wd_drain_m_tvalid", m_tvalid, 0);
    half_b();
    half_a();
    chk("wd_aborted_once", frame_aborted, 0);
    chk("wd_drain_m_tvalid2", m_tvalid, 0);
    half_b();
    half_a();
    chk("wd_release", grant_active, 0);
    chk("wd_drained", src_wr[3] - src_rd[3], 0);
    chk("wd_no_frame_done", done_cnt - d0, 0);
    chk("wd_abort_count", abort_cnt, 1);
    half_b();
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_frame_arbiter.md
# eth_tx_frame_arbiter

Frame-granular round-robin arbiter that shares the single Ethernet MAC transmit AXI-Stream sink among `NUM_PORTS` requesters (UDP/ARP/ICMP engines). It sits directly in front of the MAC TX FIFO in the `clk` domain. Once a port is granted, it holds the grant until that port's `tlast` beat transfers, so frames are never interleaved. An optional watchdog aborts stalled frames so the MAC frame FIFO discards them.

## Interface
- `NUM_PORTS`, 4, number of requesters, 2..8
- `DATA_WIDTH`, 8, tdata width per port
- `TIMEOUT_CYCLES`, 1024, mid-frame stall limit; used only with the watchdog macro

- `clk`  in  1  system clock; every port is synchronous to it
- `reset_n`  in  1  asynchronous, active-low reset
- `enable`  in  1  when low, no new grant issues; a frame in progress still completes
- `s_tdata`  in  NUM_PORTS*DATA_WIDTH  port i occupies slice [i*DATA_WIDTH +: DATA_WIDTH]
- `s_tvalid`, `s_tlast`, `s_tuser`  in  NUM_PORTS  per-port AXIS sideband
- `s_tready`  out  NUM_PORTS  per-port ready
- `m_tdata`  out  DATA_WIDTH  to MAC TX
- `m_tvalid`, `m_tlast`, `m_tuser`  out  1  to MAC TX
- `m_tready`  in  1  from MAC TX
- `grant_active`  out  1  a port currently holds the grant
- `grant_idx`  out  $clog2(NUM_PORTS)  index of the granted port; holds its last value when idle
- `frame_done`  out  1  one-cycle pulse when a granted frame's tlast beat transfers
- `frame_aborted`  out  1  one-cycle pulse when the watchdog aborts a frame; always 0 without the macro

## Operation
- States: IDLE, PASS, ABORT, DRAIN. ABORT and DRAIN exist only with the macro.
- **IDLE**
  - If `enable` is high and any `s_tvalid` is high, select the first requesting port at or after `last_grant+1` (mod NUM_PORTS).
  - Register the selection into `grant_idx`, set `grant_active`, and go to PASS.
  - In IDLE, all `s_tready` are 0 and `m_tvalid` is 0.
- **PASS**
  - The datapath is combinational: `m_tdata`, `m_tvalid`, `m_tlast`, `m_tuser` equal the granted port's signals.
  - `s_tready[grant_idx]` = `m_tready`; every other `s_tready` is 0.
  - When `m_tvalid && m_tready && m_tlast`: pulse `frame_done`, set `last_grant` = `grant_idx`, clear `grant_active`, return to IDLE.
- `tuser` passes through unmodified; the MAC FIFO handles bad-frame drop.
- Dropping `enable` during PASS has no effect until tlast.
- Round robin: a port granted last has the lowest priority next time. When all ports request continuously, grants rotate 0,1,2,3,0...

## Timing
- Reset values:
  - state IDLE
  - `last_grant` = NUM_PORTS-1, so port 0 has first priority
  - `grant_idx` 0, `grant_active` 0
  - `s_tready` 0, `m_tvalid` 0, `frame_done` 0, `frame_aborted` 0
- Arbitration takes 1 cycle: a request seen in IDLE at cycle n allows the first beat to transfer at cycle n+1 at the earliest.
- Inter-frame gap: 1 idle cycle after every tlast. Back-to-back grants are not allowed.
- Single-beat frame (tvalid and tlast together on the first beat) behaves as: grant cycle, transfer cycle, then IDLE.
- Reset asserted mid-frame: the grant is dropped immediately and outputs go to their reset values. The MAC receives a truncated frame without tlast; the system resets the MAC alongside this block.
- No combinational path exists from `s_tvalid` to `s_tready`. `m_tready` reaches `s_tready` in one gate level.

## Configuration
- Macro: `ETH_TX_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter clears on every granted-port beat transfer and increments each PASS cycle in which granted `s_tvalid` is 0.
  - When the counter reaches TIMEOUT_CYCLES, go to ABORT.
  - In ABORT, drive `m_tvalid`=1, `m_tlast`=1, `m_tuser`=1, `m_tdata`=0 until `m_tready`. Then pulse `frame_aborted` and go to DRAIN.
  - In DRAIN, `s_tready[grant_idx]`=1 and `m_tvalid`=0. Source beats are discarded until a tlast beat, then go to IDLE and update `last_grant`.
  - A stall while `m_tready` is low does not count.
- **Undefined:** no counter or ABORT/DRAIN logic; `frame_aborted` is tied to 0; a stalled port holds the grant indefinitely.

## Structure
- Package `eth_tx_arb_pkg`: state enum `arb_state_t` and the `rr_next` function for priority rotation.
- One sub-module, `rr_priority_select`: combinational round-robin pick from a request vector and a last-grant index. It outputs an index and a valid flag.

## Test plan
- Reset, then only port 2 sends a 3-byte frame {0xAA, 0xBB, 0xCC} with `m_tready`=1 → grant_idx=2 one cycle after the request, bytes appear in order with tlast on 0xCC, then `frame_done` pulses once.
- All 4 ports hold 2-beat frames continuously → grant order is 0,1,2,3,0 and frames never interleave.
- Granted port 1 mid-frame while port 0 requests, with `m_tready` toggling 1,0,1,0 → `s_tready[0]` stays 0 and port 1's beats transfer only on ready cycles.
- `enable`=0 with requests pending → no grant. Drop `enable` mid-frame → the current frame completes and no further grant issues.
- With the macro defined and TIMEOUT_CYCLES=16: port 3 stalls after 2 beats → after 16 cycles the abort beat shows tuser=1 and tlast=1, `frame_aborted` pulses, and port 3's remaining beats are drained without reaching `m_*`.
- Assert `reset_n` low mid-frame → all outputs return to their reset values asynchronously. After release, port 0 has first priority.
